// File: rtl/axi4_types.sv
// ---------------------------------------------------------------------------
// axi4_types
//   Shared AXI4-Lite type definitions: the response-code type and the
//   response-code constants used by slaves on the interconnect.
// ---------------------------------------------------------------------------
package axi4_types;

    typedef logic [1:0] axi4l_resp_t;

    localparam axi4l_resp_t AXI4_RESP_L_OKAY   = 2'b00;
    localparam axi4l_resp_t AXI4_RESP_L_SLVERR = 2'b10;
    localparam axi4l_resp_t AXI4_RESP_L_DECERR = 2'b11;

endpackage

// File: rtl/axi4l_txn_counter.sv
// ---------------------------------------------------------------------------
// axi4l_txn_counter
//   Up/down occupancy counter for owed responses (one instance per
//   response channel). Simultaneous inc and dec hold the count.
// Ports
//   clk      in   1    clock
//   rst_n    in   1    asynchronous reset, active-low
//   inc      in   1    one response became owed
//   dec      in   1    one response was delivered
//   count    out  CW   current occupancy, 0..MAX
//   nonzero  out  1    count != 0
//   full     out  1    count == MAX
// ---------------------------------------------------------------------------
module axi4l_txn_counter #(
    parameter int MAX = 4,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          full
);

    localparam logic [CW-1:0] L_MAX = CW'(MAX);

    logic [CW-1:0] r_count;
    logic          w_up;
    logic          w_down;

    // Guards keep the counter in range even if a caller misbehaves.
    assign w_up   = inc && !dec && (r_count != L_MAX);
    assign w_down = dec && !inc && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_up) begin
            r_count <= r_count + 1'b1;
        end else if (w_down) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count   = r_count;
    assign nonzero = (r_count != '0);
    assign full    = (r_count == L_MAX);

endmodule

// File: rtl/axi4l_default_slave_mo.sv
// ---------------------------------------------------------------------------
// axi4l_default_slave_mo
//   AXI4-Lite default (error) slave for unmapped address space. Accepts AW
//   and W independently in either order, keeps up to MAX_OUTSTANDING
//   responses pending per direction, answers every transaction with
//   RESP_CODE (read data RDATA_PATTERN) and records the faulting address
//   plus a saturating fault count.
// Ports
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   awvalid/awready/awaddr     write address channel
//   wvalid/wready/wdata/wstrb  write data channel (data discarded)
//   bvalid/bready/bresp        write response channel
//   arvalid/arready/araddr     read address channel
//   rvalid/rready/rdata/rresp  read data channel
//   err_clr                    synchronous clear of err_count/err_valid
//   err_valid                  a fault was recorded since reset/clear
//   err_addr                   address of most recent fault
//   err_is_write               most recent fault was a write
//   err_count                  saturating count of address handshakes
// ---------------------------------------------------------------------------
module axi4l_default_slave_mo
    import axi4_types::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter axi4l_resp_t           RESP_CODE       = AXI4_RESP_L_DECERR,
    parameter logic [DATA_WIDTH-1:0] RDATA_PATTERN   = '0,
    parameter int                    CNT_WIDTH       = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output axi4l_resp_t             bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output axi4l_resp_t             rresp,
    input  logic                    err_clr,
    output logic                    err_valid,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_is_write,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0]   L_MAX = (CW + 1)'(MAX_OUTSTANDING);

    logic                  r_init_done;
    logic [CW-1:0]         r_aw_q;
    logic [CW-1:0]         r_w_q;
    logic                  r_err_valid;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic                  r_err_is_write;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_aw_avail;
    logic                  w_w_avail;
    logic                  w_pair;
    logic [CW-1:0]         w_b_cnt;
    logic                  w_b_nz;
    logic                  w_b_full;
    logic [CW-1:0]         w_r_cnt;
    logic                  w_r_nz;
    logic                  w_r_full;
    logic                  w_aw_room;
    logic                  w_w_room;
    logic [1:0]            w_err_inc;
    logic [CNT_WIDTH-1:0]  w_err_base;
    logic [CNT_WIDTH:0]    w_err_sum;
    logic [CNT_WIDTH-1:0]  w_err_count_next;
    logic                  w_unused_ok;

    // Write data is swallowed; fold the inputs into a sink so they are visibly consumed.
    assign w_unused_ok = ^{wdata, wstrb, w_r_cnt};

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- write
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    // Unpaired AW/W entries still reserve a response slot, so each queue is
    // throttled against the responses already owed.
    assign w_aw_room = ({1'b0, r_aw_q} + {1'b0, w_b_cnt}) < L_MAX;
    assign w_w_room  = ({1'b0, r_w_q}  + {1'b0, w_b_cnt}) < L_MAX;
    assign awready   = r_init_done && !w_b_full && w_aw_room;
    assign wready    = r_init_done && !w_b_full && w_w_room;

    // A pending or arriving AW meets a pending or arriving W: one of each is
    // consumed. Only one side can ever be queued, so aw_q*w_q stays 0.
    assign w_aw_avail = (r_aw_q != '0) || w_aw_hs;
    assign w_w_avail  = (r_w_q  != '0) || w_w_hs;
    assign w_pair     = w_aw_avail && w_w_avail;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_q <= '0;
            r_w_q  <= '0;
        end else begin
            r_aw_q <= r_aw_q + CW'(w_aw_hs) - CW'(w_pair);
            r_w_q  <= r_w_q  + CW'(w_w_hs)  - CW'(w_pair);
        end
    end

    axi4l_txn_counter #(
        .MAX     (MAX_OUTSTANDING)
    ) u_b_cnt (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .inc     (w_pair),
        .dec     (bvalid && bready),
        .count   (w_b_cnt),
        .nonzero (w_b_nz),
        .full    (w_b_full)
    );

    assign bvalid = w_b_nz;
    assign bresp  = RESP_CODE;

    // ----------------------------------------------------------------- read
    assign w_ar_hs = arvalid && arready;
    assign arready = r_init_done && !w_r_full;

    axi4l_txn_counter #(
        .MAX     (MAX_OUTSTANDING)
    ) u_r_cnt (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .inc     (w_ar_hs),
        .dec     (rvalid && rready),
        .count   (w_r_cnt),
        .nonzero (w_r_nz),
        .full    (w_r_full)
    );

    assign rvalid = w_r_nz;
    assign rresp  = RESP_CODE;
    assign rdata  = RDATA_PATTERN;

    // -------------------------------------------------------- error capture
    // A clear in the same cycle as a handshake restarts the count from the
    // handshake increment instead of from zero-then-nothing.
    assign w_err_inc        = {1'b0, w_aw_hs} + {1'b0, w_ar_hs};
    assign w_err_base       = err_clr ? '0 : r_err_count;
    assign w_err_sum        = {1'b0, w_err_base} + (CNT_WIDTH + 1)'(w_err_inc);
    assign w_err_count_next = w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err_valid    <= 1'b0;
            r_err_addr     <= '0;
            r_err_is_write <= 1'b0;
            r_err_count    <= '0;
        end else if (w_aw_hs || w_ar_hs) begin
            // Write side takes priority for the captured address.
            r_err_valid    <= 1'b1;
            r_err_addr     <= w_aw_hs ? awaddr : araddr;
            r_err_is_write <= w_aw_hs;
            r_err_count    <= w_err_count_next;
        end else if (err_clr) begin
            r_err_valid    <= 1'b0;
            r_err_count    <= '0;
        end
    end

    assign err_valid    = r_err_valid;
    assign err_addr     = r_err_addr;
    assign err_is_write = r_err_is_write;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_axi4l_default_slave_mo.sv
// ---------------------------------------------------------------------------
// tb_axi4l_default_slave_mo
//   Directed bench. Two instances share all stimulus: dut_a with default
//   parameters, dut_b with SLVERR / 0xDEADBEEF / 2-bit fault counter. Both
//   have the same depth, so their handshakes are identical.
// ---------------------------------------------------------------------------
module tb_axi4l_default_slave_mo;
    import axi4_types::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0, err_clr = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = 32'h1234_5678;
    logic [3:0]  wstrb = 4'hF;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic        err_valid_a, err_is_write_a;
    axi4l_resp_t bresp_a, rresp_a;
    logic [31:0] rdata_a, err_addr_a;
    logic [15:0] err_count_a;

    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic        err_valid_b, err_is_write_b;
    axi4l_resp_t bresp_b, rresp_b;
    logic [31:0] rdata_b, err_addr_b;
    logic [1:0]  err_count_b;

    int n_vec = 0;
    int n_err = 0;
    int faults = 0;

    always #5 ACLK = ~ACLK;

    axi4l_default_slave_mo dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .awvalid(awvalid), .awready(awready_a), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready_a), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_a), .bready(bready), .bresp(bresp_a),
        .arvalid(arvalid), .arready(arready_a), .araddr(araddr),
        .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a), .rresp(rresp_a),
        .err_clr(err_clr), .err_valid(err_valid_a), .err_addr(err_addr_a),
        .err_is_write(err_is_write_a), .err_count(err_count_a)
    );

    axi4l_default_slave_mo #(
        .RESP_CODE(AXI4_RESP_L_SLVERR),
        .RDATA_PATTERN(32'hDEAD_BEEF),
        .CNT_WIDTH(2)
    ) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .awvalid(awvalid), .awready(awready_b), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready_b), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_b), .bready(bready), .bresp(bresp_b),
        .arvalid(arvalid), .arready(arready_b), .araddr(araddr),
        .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b), .rresp(rresp_b),
        .err_clr(err_clr), .err_valid(err_valid_b), .err_addr(err_addr_b),
        .err_is_write(err_is_write_b), .err_count(err_count_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_err(input string tag, input logic [31:0] addr, input logic wr);
        chk({tag, "_cnt_a"}, err_count_a, faults);
        chk({tag, "_cnt_b"}, err_count_b, (faults > 3) ? 3 : faults);
        chk({tag, "_valid"}, err_valid_a & err_valid_b, faults != 0);
        chk({tag, "_addr"}, err_addr_a, addr);
        chk({tag, "_wr"}, err_is_write_a, wr);
    endtask

    initial begin
        int acc, beats, ar_n, r_n, drops;
        logic [31:0] last_ar;
        logic prev_rv, prev_hs;

        // ---------------------------------------------------------- reset
        $display("txn reset");
        repeat (3) step();
        chk("rst_awready", awready_a, 0);
        chk("rst_wready", wready_a, 0);
        chk("rst_arready", arready_a, 0);
        chk("rst_bvalid", bvalid_a, 0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_bresp_a", bresp_a, 2'b11);
        chk("rst_bresp_b", bresp_b, 2'b10);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_rdata_b", rdata_b, 32'hDEAD_BEEF);
        check_err("rst", 32'h0, 1'b0);
        ARESETn = 1'b1;
        chk("preinit_awready", awready_a, 0);
        chk("preinit_arready", arready_b, 0);
        step();
        chk("init_awready", awready_a, 1);
        chk("init_wready", wready_a, 1);
        chk("init_arready", arready_a, 1);

        // --------------------------------------------- 1: same-cycle AW+W
        $display("txn write AW+W @40000000");
        awvalid = 1'b1; awaddr = 32'h4000_0000; wvalid = 1'b1; bready = 1'b1;
        chk("t1_bvalid_pre", bvalid_a, 0);
        step();
        awvalid = 1'b0; wvalid = 1'b0; faults = 1;
        chk("t1_bvalid", bvalid_a, 1);
        chk("t1_bresp_a", bresp_a, 2'b11);
        chk("t1_bresp_b", bresp_b, 2'b10);
        check_err("t1", 32'h4000_0000, 1'b1);
        step();
        chk("t1_bdone", bvalid_a, 0);

        // ------------------------------------------------ 2: W before AW
        $display("txn write W then AW @40000100");
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t2_noB_c1", bvalid_a, 0);
        step();
        chk("t2_noB_c2", bvalid_a, 0);
        step();
        chk("t2_noB_c3", bvalid_a, 0);
        awvalid = 1'b1; awaddr = 32'h4000_0100;
        step();
        awvalid = 1'b0; faults++;
        chk("t2_bvalid", bvalid_a, 1);
        step();
        chk("t2_single_b", bvalid_a, 0);
        // A lone AW must now wait, proving the W queue emptied.
        awvalid = 1'b1; awaddr = 32'h4000_0200;
        step();
        awvalid = 1'b0; faults++;
        step();
        chk("t2_wq_empty", bvalid_a, 0);
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t2_late_w_b", bvalid_a, 1);
        step();
        chk("t2_late_w_done", bvalid_a, 0);

        // --------------------------------------------- 3: back-pressure
        $display("txn write x6 with bready=0");
        bready = 1'b0; awvalid = 1'b1; wvalid = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            awaddr = 32'h3000 + 32'(i * 4);
            if (awready_a && wready_a) acc++;
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0; faults += acc;
        chk("t3_accepted", acc, 4);
        chk("t3_awready_full", awready_a, 0);
        chk("t3_wready_full", wready_a, 0);
        chk("t3_bvalid", bvalid_a, 1);
        check_err("t3", 32'h300C, 1'b1);
        bready = 1'b1; beats = 0;
        for (int i = 0; i < 8; i++) begin
            if (bvalid_a) beats++;
            step();
        end
        chk("t3_b_beats", beats, 4);
        chk("t3_awready_after", awready_a, 1);

        // ------------------------------------------------------ 4: reads
        $display("txn reads with rready 1010");
        ar_n = 0; r_n = 0; drops = 0; last_ar = '0;
        for (int i = 0; i < 24; i++) begin
            arvalid = (i < 8);
            araddr  = 32'h100 + 32'(i * 4);
            rready  = (i % 2 == 0);
            if (arvalid && arready_a) begin
                ar_n++;
                last_ar = araddr;
            end
            if (rvalid_a && rready) begin
                r_n++;
                chk("t4_rdata_a", rdata_a, 32'h0);
                chk("t4_rresp_a", rresp_a, 2'b11);
                chk("t4_rdata_b", rdata_b, 32'hDEAD_BEEF);
                chk("t4_rresp_b", rresp_b, 2'b10);
            end
            prev_rv = rvalid_a;
            prev_hs = rvalid_a && rready;
            step();
            if (prev_rv && !prev_hs && !rvalid_a) drops++;
        end
        arvalid = 1'b0; rready = 1'b0; faults += ar_n;
        chk("t4_ar_beats", ar_n, 7);
        chk("t4_r_eq_ar", r_n, ar_n);
        chk("t4_rvalid_drops", drops, 0);
        chk("t4_rvalid_idle", rvalid_a, 0);
        check_err("t4", last_ar, 1'b0);

        // ---------------------------------------------- 5: error capture
        $display("txn err_clr alone");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; faults = 0;
        check_err("t5_clr", last_ar, 1'b0);

        $display("txn AW@10 + AR@20 same cycle");
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1;
        arvalid = 1'b1; araddr = 32'h20; bready = 1'b1; rready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; faults = 2;
        check_err("t5_dual", 32'h10, 1'b1);

        $display("txn 3 reads toward saturation");
        for (int i = 0; i < 3; i++) begin
            arvalid = 1'b1; araddr = 32'h40 + 32'(i * 4);
            step();
        end
        arvalid = 1'b0; faults = 5;
        check_err("t5_sat", 32'h48, 1'b0);

        $display("txn err_clr with AR@80");
        err_clr = 1'b1; arvalid = 1'b1; araddr = 32'h80;
        step();
        err_clr = 1'b0; arvalid = 1'b0; faults = 1;
        check_err("t5_clr_hs", 32'h80, 1'b0);
        repeat (2) step();

        // ------------------------------------------ 6: reset mid-traffic
        $display("txn reset with 3 B and 2 R pending");
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h500; araddr = 32'h600;
        for (int i = 0; i < 3; i++) begin
            awvalid = 1'b1; wvalid = 1'b1; arvalid = (i < 2);
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t6_bvalid_pend", bvalid_a, 1);
        chk("t6_rvalid_pend", rvalid_a, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("t6_async_bvalid", bvalid_a, 0);
        chk("t6_async_rvalid", rvalid_a, 0);
        chk("t6_async_errcnt", err_count_a, 0);
        repeat (2) step();
        ARESETn = 1'b1;
        chk("t6_rel_awready", awready_a, 0);
        chk("t6_rel_wready", wready_a, 0);
        chk("t6_rel_arready", arready_a, 0);
        step();
        chk("t6_init_awready", awready_a, 1);
        chk("t6_init_arready", arready_a, 1);
        step();
        chk("t6_no_b_owed", bvalid_a, 0);
        chk("t6_no_r_owed", rvalid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
